// File: rtl/vga_circle_motion.sv
// Bouncing-circle motion controller for a VGA graphics stage.
// Debounces a run/pause switch, detects frame starts from vsync and moves the
// circle centre by STEP pixels per frame, reflecting off the screen bounds.
// Coordinates only change on the register update that raises frame_tick, so
// the graphics stage always sees a stable centre for a whole frame.
module vga_circle_motion #(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int RADIUS    = 40,
  parameter int STEP      = 2,
  parameter int DB_CYCLES = 250000
) (
  input  logic       clk,
  input  logic       reset,       // asynchronous, active low
  input  logic       vsync,       // active low
  input  logic       sw_raw,      // 1 = run
  output logic [9:0] cx,
  output logic [9:0] cy,
  output logic       running,
  output logic       frame_tick
);

  // Bounds are held in 11 bits so pos+STEP and MIN+STEP never wrap.
  localparam logic [10:0] XMIN   = 11'(RADIUS);
  localparam logic [10:0] XMAX   = 11'(H_ACTIVE - 1 - RADIUS);
  localparam logic [10:0] YMIN   = 11'(RADIUS);
  localparam logic [10:0] YMAX   = 11'(V_ACTIVE - 1 - RADIUS);
  localparam logic [10:0] STEP_W = 11'(STEP);
  localparam logic [9:0]  X_INIT = 10'(H_ACTIVE / 2);
  localparam logic [9:0]  Y_INIT = 10'(V_ACTIVE / 2);

  localparam int              DB_W    = $clog2(DB_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  typedef enum logic {
    PAUSE = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t          state;
  logic            sw_meta;
  logic            sw_sync;
  logic            sw_db;
  logic [DB_W-1:0] db_cnt;
  logic            vsync_q;
  logic            vsync_seen;
  logic            frame_start;
  logic            dx;
  logic            dy;
  logic [10:0]     x_nxt;         // {direction, position}
  logic [10:0]     y_nxt;

  // One clamp-and-reflect step on one axis; returns {new_dir, new_pos}.
  function automatic logic [10:0] axis_step(input logic [9:0]  pos,
                                            input logic        dir,
                                            input logic [10:0] lo,
                                            input logic [10:0] hi);
    logic [10:0] p;
    logic [10:0] q;
    p = {1'b0, pos};
    if (dir) begin
      q = p + STEP_W;
      if (q > hi) return {1'b0, hi[9:0]};
      else        return {1'b1, q[9:0]};
    end else begin
      q = p - STEP_W;
      if (p < lo + STEP_W) return {1'b1, lo[9:0]};
      else                 return {1'b0, q[9:0]};
    end
  endfunction

  // Two-flop synchroniser for the asynchronous switch input.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values of the others; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sw_meta <= 1'b0;
      sw_sync <= 1'b0;
    end else begin
      sw_meta <= sw_raw;
      sw_sync <= sw_meta;
    end
  end

  // Debounce: sw_db follows sw_sync only after DB_CYCLES consecutive disagreements.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sw_db  <= 1'b0;
      db_cnt <= '0;
    end else if (sw_sync == sw_db) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      sw_db  <= sw_sync;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  // Register vsync and remember whether it has been seen high since reset,
  // so a low vsync at reset release is not mistaken for a falling edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vsync_q    <= 1'b1;
      vsync_seen <= 1'b0;
    end else begin
      vsync_q    <= vsync;
      vsync_seen <= vsync_seen | vsync;
    end
  end

  // Frame-start detection and next-position computation for both axes.
  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    frame_start = 1'b0;
    x_nxt       = '0;
    y_nxt       = '0;
    frame_start = vsync_q & ~vsync & vsync_seen;
    x_nxt       = axis_step(cx, dx, XMIN, XMAX);
    y_nxt       = axis_step(cy, dy, YMIN, YMAX);
  end

  // PAUSE/RUN FSM with motion; everything updates together with frame_tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= PAUSE;
      running    <= 1'b0;
      frame_tick <= 1'b0;
      cx         <= X_INIT;
      cy         <= Y_INIT;
      dx         <= 1'b1;
      dy         <= 1'b1;
    end else begin
      frame_tick <= frame_start;
      if (frame_start) begin
        unique case (state)
          PAUSE: begin
            if (sw_db) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
          RUN: begin
            {dx, cx} <= x_nxt;
            {dy, cy} <= y_nxt;
            if (!sw_db) begin
              state   <= PAUSE;
              running <= 1'b0;
            end
          end
          default: begin
            state   <= PAUSE;
            running <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vga_circle_motion.sv
// Directed bench for vga_circle_motion. A default-sized instance covers
// debounce, run start, x bounce, pause and reset; a square-screen instance
// driven by the same stimulus reaches a corner to cover a double reflection.
module tb_vga_circle_motion;

  logic       clk = 1'b0;
  logic       reset;
  logic       vsync;
  logic       sw_raw;
  logic [9:0] cx, cy;
  logic       running, frame_tick;
  logic [9:0] cx2, cy2;
  logic       running2, frame_tick2;

  int n_checks = 0;
  int n_fail   = 0;
  int ticks    = 0;  // frame_tick pulse-cycles of the default instance
  int ticks2   = 0;
  int t0;

  vga_circle_motion #(.DB_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .vsync(vsync), .sw_raw(sw_raw),
    .cx(cx), .cy(cy), .running(running), .frame_tick(frame_tick)
  );

  // Square screen: both axes start at 320 and clamp at 599 on the same tick.
  vga_circle_motion #(.H_ACTIVE(640), .V_ACTIVE(640), .DB_CYCLES(4)) dut_sq (
    .clk(clk), .reset(reset), .vsync(vsync), .sw_raw(sw_raw),
    .cx(cx2), .cy(cy2), .running(running2), .frame_tick(frame_tick2)
  );

  always #20 clk = ~clk;

  // Count every cycle frame_tick is high (sampled before the edge's updates).
  always @(posedge clk) begin
    if (frame_tick === 1'b1)  ticks++;
    if (frame_tick2 === 1'b1) ticks2++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One frame: vsync low for 2 cycles then high for 2; the tick lands on the
  // first posedge after vsync falls.
  task automatic frame();
    vsync = 1'b0;
    cyc(2);
    vsync = 1'b1;
    cyc(2);
  endtask

  task automatic frames(input int n);
    repeat (n) frame();
  endtask

  initial begin
    reset  = 1'b0;
    vsync  = 1'b1;
    sw_raw = 1'b0;
    cyc(3);
    check("reset_cx", 32'(cx), 320);
    check("reset_cy", 32'(cy), 240);
    check("reset_running", 32'(running), 0);
    check("reset_tick", 32'(frame_tick), 0);
    reset = 1'b1;
    cyc(2);

    // 3-cycle glitch must not get through a 4-cycle debounce.
    sw_raw = 1'b1;
    cyc(3);
    sw_raw = 1'b0;
    cyc(6);
    t0 = ticks;
    frames(2);
    check("glitch_running", 32'(running), 0);
    check("glitch_cx", 32'(cx), 320);
    check("glitch_cy", 32'(cy), 240);
    check("paused_ticks", 32'(ticks - t0), 2);

    // Run start: debounced switch, first tick only changes state.
    sw_raw = 1'b1;
    cyc(7);
    frame();
    check("start_running", 32'(running), 1);
    check("start_cx", 32'(cx), 320);
    check("start_cy", 32'(cy), 240);
    frame();
    check("move1_cx", 32'(cx), 322);
    check("move1_cy", 32'(cy), 242);

    // 90 moves: x=500; y=420 (not yet at 439).
    frames(89);
    check("pre_reset_cx", 32'(cx), 500);
    check("pre_reset_cy", 32'(cy), 420);

    // One-cycle reset mid-run with vsync held low through release.
    vsync = 1'b0;
    reset = 1'b0;
    #1;
    check("async_reset_cx", 32'(cx), 320);
    check("async_reset_cy", 32'(cy), 240);
    check("async_reset_running", 32'(running), 0);
    t0 = ticks;
    cyc(1);
    reset = 1'b1;
    cyc(4);
    check("no_tick_after_reset", 32'(ticks - t0), 0);
    check("no_tick_level", 32'(frame_tick), 0);
    vsync = 1'b1;
    cyc(4);
    check("no_tick_on_rise", 32'(ticks - t0), 0);
    frame();
    check("fresh_edge_tick", 32'(ticks - t0), 1);
    check("restart_running", 32'(running), 1);
    check("restart_cx", 32'(cx), 320);

    // 139 moves: x=598; y hit 439 at move 100 then fell 39 steps to 361.
    // Square instance: 598/598.
    frames(139);
    check("x598_cx", 32'(cx), 598);
    check("x598_cy", 32'(cy), 361);
    check("sq598_cx", 32'(cx2), 598);
    check("sq598_cy", 32'(cy2), 598);
    frame();
    check("xclamp_cx", 32'(cx), 599);
    check("xclamp_cy", 32'(cy), 359);
    check("corner_cx", 32'(cx2), 599);
    check("corner_cy", 32'(cy2), 599);
    frame();
    check("xreflect_cx", 32'(cx), 597);
    check("xreflect_cy", 32'(cy), 357);
    check("corner_reflect_cx", 32'(cx2), 597);
    check("corner_reflect_cy", 32'(cy2), 597);

    // Pause: one final step on the leaving tick, then frozen.
    sw_raw = 1'b0;
    cyc(8);
    check("still_running", 32'(running), 1);
    frame();
    check("pause_running", 32'(running), 0);
    check("pause_cx", 32'(cx), 595);
    check("pause_cy", 32'(cy), 355);
    t0 = ticks;
    frames(3);
    check("frozen_cx", 32'(cx), 595);
    check("frozen_cy", 32'(cy), 355);
    check("frozen_ticks", 32'(ticks - t0), 3);
    check("sq_frozen_cx", 32'(cx2), 595);
    check("sq_ticks_match", 32'(ticks2), 32'(ticks));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
